// File: rtl/adder_accum_pkg.sv
// adder_accum_pkg: shared state encoding and data width for the accumulator slice
package adder_accum_pkg;
  localparam int DATA_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/adder_accum_if.sv
// adder_accum_if: burst control, input handshake and result signals of adder_accum
interface adder_accum_if #(parameter int LEN_W = 4);
  import adder_accum_pkg::*;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic              out_valid;
  logic              busy;
  modport master (output start, len, in_valid, in_data,
                  input  in_ready, sum, ovf, out_valid, busy);
  modport slave  (input  start, len, in_valid, in_data,
                  output in_ready, sum, ovf, out_valid, busy);
endinterface

// File: rtl/adder_ripple.sv
// adder_ripple: W-bit ripple-carry adder, sum modulo 2^W with no carry-out
module adder_ripple
  import adder_accum_pkg::*;
#(parameter int W = DATA_W) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q
);
  logic [W-1:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign q[i] = a[i] ^ b[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/adder_accum.sv
// adder_accum: burst accumulator around adder_ripple with sticky carry-out flag
module adder_accum
  import adder_accum_pkg::*;
#(parameter int LEN_W = 4) (
  input logic clk,
  input logic rst,
  adder_accum_if.slave bus
);
  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] q;
  logic [LEN_W-1:0]  remaining;
  adder_ripple #(.W(DATA_W)) u_add (.a(acc), .b(bus.in_data), .q(q));
  assign bus.sum = acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      bus.ovf       <= 1'b0;
      remaining     <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          remaining     <= bus.len;
          acc           <= '0;
          bus.ovf       <= 1'b0;
          state         <= (bus.len != '0) ? ACCUM : DONE;
          bus.in_ready  <= bus.len != '0;
          bus.out_valid <= bus.len == '0;
          bus.busy      <= 1'b1;
        end
        ACCUM: if (bus.in_valid && bus.in_ready) begin
          acc       <= q;
          // wrap of the modulo sum is the only evidence of a carry-out
          bus.ovf   <= bus.ovf | (q < acc);
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state         <= DONE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_accum.sv
// tb_adder_accum: directed and randomized bursts checked against a plain-arithmetic model
module tb_adder_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [3:0] words [16];
  adder_accum_if #(.LEN_W(4)) bus();
  adder_accum #(.LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // expected result: total of the words; a carry happened iff the true total exceeds 15
  task automatic burst(input int n, input int gap, input bit rnd, input bit poke);
    int tot = 0;
    chk("idle_ready", bus.in_ready, 0);
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.len = 4'(n);
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      int b = (k == 0) ? 0 : (rnd ? int'($urandom_range(0, 3)) : gap);
      for (int j = 0; j < b; j++) begin
        bus.in_valid = 1'b0;
        bus.in_data = 4'($urandom);
        bus.start = poke;
        bus.len = 4'd7;
        tick;
        bus.start = 1'b0;
        chk("bubble_sum", bus.sum, 8'(tot % 16));
        chk("bubble_ready", bus.in_ready, 1);
      end
      chk("accum_ready", bus.in_ready, 1);
      chk("accum_busy", bus.busy, 1);
      bus.in_valid = 1'b1;
      bus.in_data = words[k];
      tick;
      tot += int'(words[k]);
      chk("beat_sum", bus.sum, 8'(tot % 16));
      chk("beat_ovf", bus.ovf, 8'(tot > 15));
      chk("beat_out_valid", bus.out_valid, 8'(k == n - 1));
    end
    chk("done_valid", bus.out_valid, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_ready", bus.in_ready, 0);
    chk("done_sum", bus.sum, 8'(tot % 16));
    chk("done_ovf", bus.ovf, 8'(tot > 15));
    bus.in_valid = 1'b1;
    bus.in_data = 4'hf;
    bus.start = 1'b1;
    bus.len = 4'd5;
    tick;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("after_valid", bus.out_valid, 0);
    chk("after_busy", bus.busy, 0);
    chk("hold_sum", bus.sum, 8'(tot % 16));
    chk("hold_ovf", bus.ovf, 8'(tot > 15));
    tick;
    chk("idle_hold_sum", bus.sum, 8'(tot % 16));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    tick;
    chk("rst_sum", bus.sum, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    tick;
    words[0] = 4'd1; words[1] = 4'd2; words[2] = 4'd3;
    burst(3, 0, 1'b0, 1'b0);
    words[0] = 4'hf; words[1] = 4'hf;
    burst(2, 0, 1'b0, 1'b0);
    words[0] = 4'h4;
    burst(1, 0, 1'b0, 1'b0);
    burst(0, 0, 1'b0, 1'b0);
    words[0] = 4'h5; words[1] = 4'h0; words[2] = 4'ha; words[3] = 4'h1;
    burst(4, 2, 1'b0, 1'b0);
    words[0] = 4'h3; words[1] = 4'h4;
    burst(2, 1, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.len = 4'd4;
    tick;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 4'h7;
    tick;
    bus.in_data = 4'h8;
    tick;
    bus.in_valid = 1'b0;
    chk("pre_rst_sum", bus.sum, 8'hf);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_sum", bus.sum, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_ready", bus.in_ready, 0);
    chk("async_rst_valid", bus.out_valid, 0);
    tick;
    rst = 1'b0;
    tick;
    words[0] = 4'h9;
    burst(1, 0, 1'b0, 1'b0);
    for (int r = 0; r < 25; r++) begin
      int n = int'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) words[k] = 4'($urandom);
      burst(n, 0, 1'b1, 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
